// File: rtl/simmem_write_resp_releaser.sv
// Release-token generator for the write response bank: times each reserved response's delay
// in a slot and grants one per-ID release token on expiry. Option macro: SIMMEM_RELEASER_ZERO_DELAY_BYPASS_EN.
module simmem_write_resp_releaser #(
  parameter int NumIds     = 4,
  parameter int IDWidth    = $clog2(NumIds),
  parameter int NumSlots   = 8,
  parameter int DelayWidth = 8,
  localparam int CntWidth  = $clog2(NumSlots + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  delay_valid_i,
  output logic                  delay_ready_o,
  input  logic [IDWidth-1:0]    delay_id_i,
  input  logic [DelayWidth-1:0] delay_i,
  output logic [NumIds-1:0]     release_en_o,
  input  logic [NumIds-1:0]     rel_id_onehot_i,
  output logic [CntWidth-1:0]   outstanding_o
);

  localparam int OccWidth = CntWidth + 2;

  logic                  slot_valid_reg [NumSlots];
  logic [IDWidth-1:0]    slot_id_reg    [NumSlots];
  logic [DelayWidth-1:0] slot_cnt_reg   [NumSlots];
  logic [CntWidth-1:0]   tok_reg        [NumIds];

  logic [NumSlots-1:0] expire;
  logic [NumSlots-1:0] slot_load;
  logic                alloc_found;
  logic [CntWidth-1:0] exp_cnt [NumIds];
  logic [NumIds-1:0]   consume;
  logic [NumIds-1:0]   bypass_inc;
  logic                handshake;
  logic                zero_bypass;
  logic                to_slot;
  logic                onehot_ok;
  logic [OccWidth-1:0] occupancy;

  assign handshake = delay_valid_i & delay_ready_o;

`ifdef SIMMEM_RELEASER_ZERO_DELAY_BYPASS_EN
  assign zero_bypass = (delay_i == '0);
`else
  assign zero_bypass = 1'b0;
`endif

  assign to_slot   = handshake & ~zero_bypass;
  assign onehot_ok = $onehot(rel_id_onehot_i);

  // Lowest-index slot that is free right now; a slot expiring this cycle is still marked valid.
  always_comb begin
    slot_load   = '0;
    alloc_found = 1'b0;
    for (int s = 0; s < NumSlots; s++) begin
      if (!alloc_found && !slot_valid_reg[s]) begin
        alloc_found  = 1'b1;
        slot_load[s] = to_slot;
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NumIds; i++) begin
      exp_cnt[i] = '0;
      for (int s = 0; s < NumSlots; s++) begin
        if (expire[s] && (slot_id_reg[s] == IDWidth'(i))) begin
          exp_cnt[i] = exp_cnt[i] + CntWidth'(1);
        end
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NumSlots; gi++) begin : g_slot
      assign expire[gi] = slot_valid_reg[gi] && (slot_cnt_reg[gi] == '0);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          slot_valid_reg[gi] <= 1'b0;
          slot_id_reg[gi]    <= '0;
          slot_cnt_reg[gi]   <= '0;
        end else if (slot_load[gi]) begin
          slot_valid_reg[gi] <= 1'b1;
          slot_id_reg[gi]    <= delay_id_i;
          slot_cnt_reg[gi]   <= delay_i;
        end else if (slot_valid_reg[gi]) begin
          if (slot_cnt_reg[gi] == '0) begin
            slot_valid_reg[gi] <= 1'b0;
          end else begin
            slot_cnt_reg[gi] <= slot_cnt_reg[gi] - DelayWidth'(1);
          end
        end
      end
    end

    for (gi = 0; gi < NumIds; gi++) begin : g_id
      // Illegal feedback (multi-hot, or an ID holding no token) is dropped here.
      assign consume[gi]    = onehot_ok & rel_id_onehot_i[gi] & (tok_reg[gi] != '0);
      assign bypass_inc[gi] = handshake & zero_bypass & (delay_id_i == IDWidth'(gi));
      assign release_en_o[gi] = (tok_reg[gi] != '0);

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          tok_reg[gi] <= '0;
        end else begin
          tok_reg[gi] <= tok_reg[gi] + exp_cnt[gi] + CntWidth'(bypass_inc[gi])
                         - CntWidth'(consume[gi]);
        end
      end
    end
  endgenerate

  // Expiry only moves credit from a slot to a token, so only a consume lowers occupancy.
  always_comb begin
    occupancy = '0;
    for (int s = 0; s < NumSlots; s++) begin
      occupancy = occupancy + OccWidth'(slot_valid_reg[s]);
    end
    for (int i = 0; i < NumIds; i++) begin
      occupancy = occupancy + OccWidth'(tok_reg[i]);
    end
  end

  assign delay_ready_o = (occupancy < OccWidth'(NumSlots));
  assign outstanding_o = occupancy[CntWidth-1:0];

endmodule
